// File: rtl/arbiter_pkg.sv
// Shared state encoding and default widths for the fetch/data memory arbiter.
package arbiter_pkg;

    localparam int DEFAULT_DATA_W  = 32;
    localparam int DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates fetch (I) and MEM-stage (D) requests onto one single-port memory,
// holding per-port completion until the pipeline advances.
module mem_arbiter
    import arbiter_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [DATA_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [DATA_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    input  logic              advance,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err
);

    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              iDone_q, iDone_d;
    logic              dDone_q, dDone_d;
    logic [DATA_W-1:0] iRdata_q, iRdata_d;
    logic [DATA_W-1:0] dRdata_q, dRdata_d;
    logic              memWe_q, memWe_d;
    logic [DATA_W-1:0] memAddr_q, memAddr_d;
    logic [DATA_W-1:0] memWdata_q, memWdata_d;
    logic              err_q, err_d;
    logic              busyFinish;
    logic              busyTimeout;

    // A completion in the same cycle as advance must survive, so the clear is applied first.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        iDone_d     = advance ? 1'b0 : iDone_q;
        dDone_d     = advance ? 1'b0 : dDone_q;
        iRdata_d    = iRdata_q;
        dRdata_d    = dRdata_q;
        memWe_d     = memWe_q;
        memAddr_d   = memAddr_q;
        memWdata_d  = memWdata_q;
        err_d       = err_q;
        busyFinish  = 1'b0;
        busyTimeout = 1'b0;

        case (state_q)
            IDLE: begin
                if (d_req && !dDone_q) begin
                    state_d    = D_BUSY;
                    cnt_d      = '0;
                    memWe_d    = d_we;
                    memAddr_d  = d_addr;
                    memWdata_d = d_wdata;
                end else if (i_req && !iDone_q) begin
                    state_d    = I_BUSY;
                    cnt_d      = '0;
                    memWe_d    = 1'b0;
                    memAddr_d  = i_addr;
                    memWdata_d = '0;
                end
            end
            I_BUSY, D_BUSY: begin
                if (mem_ready) begin
                    busyFinish = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    busyFinish  = 1'b1;
                    busyTimeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end

                // A timed-out access still completes, but with a zero result and the sticky error.
                if (busyFinish) begin
                    state_d = IDLE;
                    memWe_d = 1'b0;
                    if (busyTimeout) begin
                        err_d = 1'b1;
                    end
                    if (state_q == I_BUSY) begin
                        iDone_d  = 1'b1;
                        iRdata_d = busyTimeout ? '0 : mem_rdata;
                    end else begin
                        dDone_d = 1'b1;
                        if (busyTimeout) begin
                            dRdata_d = '0;
                        end else if (!memWe_q) begin
                            dRdata_d = mem_rdata;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            iDone_q    <= 1'b0;
            dDone_q    <= 1'b0;
            iRdata_q   <= '0;
            dRdata_q   <= '0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            iDone_q    <= iDone_d;
            dDone_q    <= dDone_d;
            iRdata_q   <= iRdata_d;
            dRdata_q   <= dRdata_d;
            memWe_q    <= memWe_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            err_q      <= err_d;
        end
    end

    assign mem_req   = (state_q != IDLE);
    assign mem_we    = memWe_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;
    assign i_rdata   = iRdata_q;
    assign d_rdata   = dRdata_q;
    assign i_stall   = i_req & ~iDone_q;
    assign d_stall   = d_req & ~dDone_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vectors, corner sequences and a
// randomized run against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int DW  = 32;
    localparam int TMO = 4;

    typedef struct {
        bit          isD;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] expRdata;
        int          expEdges;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req;
    logic [DW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_stall;
    logic          d_req;
    logic          d_we;
    logic [DW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_stall;
    logic          advance;
    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          err;

    int nCompared   = 0;
    int nMismatched = 0;
    int memLat      = 0;
    int memWait     = 0;

    bit          mBusy, mPortD, mWe, mTimed, mIDone, mDDone, mErr;
    int          mRem;
    logic [31:0] mAddr, mIRdata, mDRdata;

    vec_t vecs[5];

    mem_arbiter #(.DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_stall(i_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_stall(d_stall), .advance(advance),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memImage(input logic [31:0] addr);
        if (addr == 32'h40) return 32'hDEADBEEF;
        return addr ^ 32'h5A5A_0000;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    // Memory responder: pulses mem_ready on the memLat-th cycle of a request (0 = never).
    task automatic step();
        @(posedge clk);
        #1;
        if (mem_req) memWait++;
        else memWait = 0;
        mem_ready = mem_req && memLat != 0 && memWait == memLat;
        mem_rdata = mem_ready ? memImage(mem_addr) : 32'h0BAD_0BAD;
    endtask

    task automatic clearPort();
        i_req   = 1'b0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        advance = 1'b1;
        step();
        advance = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        int   edges  = 0;
        bit   sawCmd = 0;
        logic stallNow = 1'b1;
        memLat = v.lat;
        if (v.isD) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            i_req = 1'b1; i_addr = v.addr;
        end
        while (stallNow && edges < 20) begin
            step();
            edges++;
            if (mem_req && !sawCmd) begin
                sawCmd = 1;
                checkOutput($sformatf("vec%0d mem_addr", idx), mem_addr, v.addr);
                checkBit($sformatf("vec%0d mem_we", idx), mem_we, v.we);
                if (v.we) checkOutput($sformatf("vec%0d mem_wdata", idx), mem_wdata, v.wdata);
            end
            stallNow = v.isD ? d_stall : i_stall;
        end
        checkOutput($sformatf("vec%0d stall cycles", idx), edges, v.expEdges);
        checkOutput($sformatf("vec%0d rdata", idx), v.isD ? d_rdata : i_rdata, v.expRdata);
        clearPort();
    endtask

    task automatic startTxn(input bit portD, input logic [31:0] addr, input bit we);
        mBusy  = 1;
        mPortD = portD;
        mAddr  = addr;
        mWe    = we;
        mTimed = (memLat == 0 || memLat > TMO);
        mRem   = mTimed ? TMO : memLat;
    endtask

    // Transaction-level model: a granted access lasts min(latency, TIMEOUT) cycles.
    task automatic modelEdge();
        bit setI = 0;
        bit setD = 0;
        if (mBusy) begin
            mRem--;
            if (mRem == 0) begin
                mBusy = 0;
                if (mPortD) begin
                    setD = 1;
                    if (mTimed) mDRdata = 32'h0;
                    else if (!mWe) mDRdata = memImage(mAddr);
                end else begin
                    setI = 1;
                    mIRdata = mTimed ? 32'h0 : memImage(mAddr);
                end
                if (mTimed) mErr = 1;
            end
        end else if (d_req && !mDDone) begin
            startTxn(1, d_addr, d_we);
        end else if (i_req && !mIDone) begin
            startTxn(0, i_addr, 1'b0);
        end
        mIDone = setI || (mIDone && !advance);
        mDDone = setD || (mDDone && !advance);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          edges;
        int          txn;
        int          weRises;
        int          dStallBad;
        bit          prevReq;
        bit          prevWe;
        bit          dDropped;
        bit          sawCmd;
        logic        stallNow;
        logic        firstWe;
        logic [31:0] firstAddr, secondAddr, wdataSeen, weAddr, cmdAddr;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0, 3, 32'hDEADBEEF, 4};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0, 1, 32'h5A5A_0100, 2};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0200, 32'h1234_5678, 2, 32'h5A5A_0100, 3};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_003C, 32'h0, 4, 32'h5A5A_003C, 5};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0, 4, 32'h5A5A_0008, 5};

        rst = 1'b0; i_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
        i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; advance = 1'b0;
        mem_ready = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checkBit("reset mem_req", mem_req, 1'b0);
        checkBit("reset mem_we", mem_we, 1'b0);
        checkBit("reset err", err, 1'b0);
        checkOutput("reset mem_addr", mem_addr, 32'h0);
        checkOutput("reset mem_wdata", mem_wdata, 32'h0);
        checkOutput("reset i_rdata", i_rdata, 32'h0);
        checkOutput("reset d_rdata", d_rdata, 32'h0);
        checkBit("reset i_stall", i_stall, 1'b1);
        checkBit("reset d_stall", d_stall, 1'b1);
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        #2;
        rst = 1'b1;

        // Spurious mem_ready while idle must not complete anything.
        i_req = 1'b1; i_addr = 32'h3C; memLat = 2;
        mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        step();
        checkBit("spurious i_stall", i_stall, 1'b1);
        checkOutput("spurious i_rdata", i_rdata, 32'h0);
        edges = 0; stallNow = 1'b1;
        while (stallNow && edges < 20) begin
            step(); edges++; stallNow = i_stall;
        end
        checkOutput("spurious then served cycles", edges, 2);
        checkOutput("spurious then served rdata", i_rdata, 32'h5A5A_003C);
        clearPort();

        for (int k = 0; k < 5; k++) applyStimulus(vecs[k], k);

        i_req = 1'b1; i_addr = 32'h44;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; memLat = 2;
        edges = 0; txn = 0; prevReq = 0; stallNow = 1'b1;
        firstAddr = 32'h0; firstWe = 1'bx; secondAddr = 32'h0;
        while (stallNow && edges < 20) begin
            step(); edges++;
            if (mem_req && !prevReq) begin
                if (txn == 0) begin firstAddr = mem_addr; firstWe = mem_we; end
                else if (txn == 1) secondAddr = mem_addr;
                txn++;
            end
            prevReq = mem_req;
            stallNow = i_stall;
        end
        checkOutput("collision txn count", txn, 2);
        checkOutput("collision first addr", firstAddr, 32'h100);
        checkBit("collision first we", firstWe, 1'b0);
        checkOutput("collision second addr", secondAddr, 32'h44);
        checkOutput("collision i_stall cycles", edges, 6);
        checkBit("collision d_stall", d_stall, 1'b0);
        checkOutput("collision d_rdata", d_rdata, 32'h5A5A_0100);
        checkOutput("collision i_rdata", i_rdata, 32'h5A5A_0044);
        clearPort();

        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'hCAFE_F00D;
        i_req = 1'b1; i_addr = 32'h48; memLat = 2;
        weRises = 0; prevWe = 0; dDropped = 0; dStallBad = 0;
        wdataSeen = 32'h0; weAddr = 32'h0;
        repeat (16) begin
            step();
            if (mem_we && !prevWe) begin
                weRises++; wdataSeen = mem_wdata; weAddr = mem_addr;
            end
            prevWe = mem_we;
            if (!d_stall) dDropped = 1;
            else if (dDropped) dStallBad++;
        end
        checkOutput("sticky we pulses", weRises, 1);
        checkOutput("sticky wdata", wdataSeen, 32'hCAFE_F00D);
        checkOutput("sticky write addr", weAddr, 32'h300);
        checkBit("sticky d_stall dropped", dDropped, 1'b1);
        checkOutput("sticky d_stall reasserted", dStallBad, 0);
        checkBit("sticky i_stall", i_stall, 1'b0);
        checkOutput("sticky i_rdata", i_rdata, 32'h5A5A_0048);
        checkOutput("sticky d_rdata kept", d_rdata, 32'h5A5A_0100);
        advance = 1'b1;
        step();
        checkBit("advance rearms d_stall", d_stall, 1'b1);
        checkBit("advance rearms i_stall", i_stall, 1'b1);
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; advance = 1'b0;
        step();
        checkBit("advance no new grant", mem_req, 1'b0);

        i_req = 1'b1; i_addr = 32'h50; memLat = 0;
        step();
        checkBit("timeout mem_req start", mem_req, 1'b1);
        repeat (3) step();
        checkBit("timeout busy after 3", mem_req, 1'b1);
        checkBit("timeout err before", err, 1'b0);
        step();
        checkBit("timeout err", err, 1'b1);
        checkBit("timeout back idle", mem_req, 1'b0);
        checkOutput("timeout i_rdata", i_rdata, 32'h0);
        checkBit("timeout i_stall", i_stall, 1'b0);
        clearPort();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8; memLat = 1;
        edges = 0; stallNow = 1'b1;
        while (stallNow && edges < 20) begin
            step(); edges++; stallNow = d_stall;
        end
        checkOutput("post-timeout cycles", edges, 2);
        checkOutput("post-timeout d_rdata", d_rdata, 32'h5A5A_0008);
        checkBit("post-timeout err sticky", err, 1'b1);
        clearPort();

        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; memLat = 0;
        step();
        checkBit("midreset busy", mem_req, 1'b1);
        step();
        #2;
        rst = 1'b0;
        #1;
        checkBit("midreset mem_req", mem_req, 1'b0);
        checkBit("midreset err", err, 1'b0);
        checkOutput("midreset d_rdata", d_rdata, 32'h0);
        checkBit("midreset d_stall", d_stall, 1'b1);
        memWait = 0; memLat = 2; mem_ready = 1'b0;
        #1;
        rst = 1'b1;
        edges = 0; sawCmd = 0; cmdAddr = 32'h0; stallNow = 1'b1;
        while (stallNow && edges < 20) begin
            step(); edges++;
            if (mem_req && !sawCmd) begin sawCmd = 1; cmdAddr = mem_addr; end
            stallNow = d_stall;
        end
        checkOutput("midreset regrant addr", cmdAddr, 32'h100);
        checkOutput("midreset regrant cycles", edges, 3);
        checkOutput("midreset d_rdata after", d_rdata, 32'h5A5A_0100);
        clearPort();

        rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; advance = 1'b0;
        mem_ready = 1'b0; memWait = 0; memLat = 0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        mBusy = 0; mIDone = 0; mDDone = 0; mErr = 0; mRem = 0;
        mIRdata = 32'h0; mDRdata = 32'h0; mAddr = 32'h0; mWe = 0; mPortD = 0; mTimed = 0;
        for (int c = 0; c < 600; c++) begin
            modelEdge();
            step();
            checkBit($sformatf("rnd%0d mem_req", c), mem_req, mBusy);
            checkBit($sformatf("rnd%0d i_stall", c), i_stall, i_req && !mIDone);
            checkBit($sformatf("rnd%0d d_stall", c), d_stall, d_req && !mDDone);
            checkOutput($sformatf("rnd%0d i_rdata", c), i_rdata, mIRdata);
            checkOutput($sformatf("rnd%0d d_rdata", c), d_rdata, mDRdata);
            checkBit($sformatf("rnd%0d err", c), err, mErr);
            if (mBusy) begin
                checkOutput($sformatf("rnd%0d mem_addr", c), mem_addr, mAddr);
                checkBit($sformatf("rnd%0d mem_we", c), mem_we, mWe);
            end
            if (!mem_req) memLat = $urandom_range(0, 5);
            i_req   = ($urandom_range(0, 3) != 0);
            d_req   = ($urandom_range(0, 1) != 0);
            d_we    = ($urandom_range(0, 1) != 0);
            advance = ($urandom_range(0, 3) == 0);
            i_addr  = $urandom & 32'hFFFF_FFFC;
            d_addr  = $urandom & 32'hFFFF_FFFC;
            d_wdata = $urandom;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
